// File: rtl/vg8020_ram_if.sv
// Z80 slot-3 strobe/address bundle between the board bus and the main RAM.
// The master drives the delayed strobes and address; the RAM reports ready.
interface vg8020_ram_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  nmreq;
    logic                  nmreqd;
    logic                  nrdd;
    logic                  nrfshd;
    logic                  nsltsl3;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ready;

    modport master (
        output nmreq, nmreqd, nrdd, nrfshd, nsltsl3, addr,
        input  ready
    );

    modport slave (
        input  nmreq, nmreqd, nrdd, nrfshd, nsltsl3, addr,
        output ready
    );
endinterface

// File: rtl/vg8020_ram.sv
// VG8020 64 KiB main RAM in primary slot 3: stores bytes on write cycles and drives the data bus on reads.
// Read latency 1 clock from a stable address; bus release is combinational. Optional macro RAM_CLEAR_ON_RESET_EN zeroes the array after reset.
module vg8020_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    vg8020_ram_if.slave           bus,
    inout  wire  [DATA_WIDTH-1:0] data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  rst_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic sel, rd_cyc, wr_cyc, wr_en, oe, ready;

    // Refresh cycles never select the RAM, so they cannot read or write.
    assign sel    = !bus.nsltsl3 && !bus.nmreqd && bus.nrfshd;
    assign rd_cyc = sel && !bus.nrdd;
    assign wr_cyc = sel && bus.nrdd;

`ifdef RAM_CLEAR_ON_RESET_EN
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    assign ready = !rst && !rst_q && (state_q != CLEAR);
    assign wr_en = wr_cyc && ready;
`else
    assign ready = !rst && !rst_q;
    assign wr_en = wr_cyc;
`endif

    assign bus.ready = ready;
    assign oe        = rd_cyc && !bus.nmreq && ready && !rst_q;
    assign data      = oe ? rdata_q : {DATA_WIDTH{1'bz}};

    always_comb begin
        state_d = state_q;
`ifdef RAM_CLEAR_ON_RESET_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (rd_cyc)      state_d = READ;
                else if (wr_cyc) state_d = WRITE;
            end
            READ: begin
                if (wr_cyc)       state_d = WRITE;
                else if (!rd_cyc) state_d = IDLE;
            end
            WRITE: begin
                if (rd_cyc)       state_d = READ;
                else if (!wr_cyc) state_d = IDLE;
            end
            default: begin
`ifdef RAM_CLEAR_ON_RESET_EN
                clr_cnt_d = clr_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef RAM_CLEAR_ON_RESET_EN
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
`else
            state_q   <= IDLE;
`endif
            rst_q     <= 1'b1;
            rdata_q   <= '0;
        end else begin
`ifdef RAM_CLEAR_ON_RESET_EN
            clr_cnt_q <= clr_cnt_d;
`endif
            state_q   <= state_d;
            rst_q     <= 1'b0;
            rdata_q   <= mem[bus.addr];
        end
    end

    // The array itself has no reset; contents survive rst unless the clear sweep runs.
    always_ff @(posedge clk) begin
`ifdef RAM_CLEAR_ON_RESET_EN
        if (!rst && state_q == CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            mem[bus.addr] <= data;
        end
`else
        if (wr_en) begin
            mem[bus.addr] <= data;
        end
`endif
    end
endmodule

// File: tb/tb_vg8020_ram.sv
// Randomized bench for vg8020_ram against an array model of the 64 KiB RAM.
// Covers directed plan items, random write/read/refresh/deselect traffic, and reset behaviour.
module tb_vg8020_ram;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vg8020_ram_if #(.ADDR_WIDTH(16)) bus ();

    wire  [7:0] data;
    logic [7:0] tb_dat;
    logic       tb_drv;
    logic       bus_z;
    assign data  = tb_drv ? tb_dat : 8'bz;
    assign bus_z = (data === 8'bz);

    vg8020_ram #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .data (data)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl   [0:65535];
    bit         known [0:65535];
    logic [15:0] wr_addrs [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.nmreq   = 1'b1;
        bus.nmreqd  = 1'b1;
        bus.nrdd    = 1'b1;
        bus.nrfshd  = 1'b1;
        bus.nsltsl3 = 1'b1;
        tb_drv      = 1'b0;
    endtask

    // Memory write cycle; slot and refresh control whether the model updates.
    task automatic wr(input logic [15:0] a, input logic [7:0] d, input bit slot, input bit rfsh);
        @(negedge clk);
        bus.addr    = a;
        tb_dat      = d;
        tb_drv      = 1'b1;
        bus.nsltsl3 = !slot;
        bus.nrfshd  = !rfsh;
        bus.nrdd    = 1'b1;
        bus.nmreq   = 1'b0;
        bus.nmreqd  = 1'b0;
        @(negedge clk);
        idle_bus();
        #1 chk("wr_release_z", bus_z, 1'b1);
        if (slot && !rfsh) begin
            mdl[a]   = d;
            if (!known[a]) wr_addrs.push_back(a);
            known[a] = 1'b1;
        end
    endtask

    task automatic rd(input logic [15:0] a);
        @(negedge clk);
        chk("rd_pre_z", bus_z, 1'b1);
        bus.addr    = a;
        bus.nsltsl3 = 1'b0;
        bus.nrfshd  = 1'b1;
        bus.nrdd    = 1'b0;
        bus.nmreq   = 1'b0;
        bus.nmreqd  = 1'b0;
        @(negedge clk);
        if (known[a]) chk($sformatf("rd_%04h", a), data, mdl[a]);
        else          chk("rd_driven", bus_z, 1'b0);
        idle_bus();
        #1 chk("rd_release_z", bus_z, 1'b1);
    endtask

    // Read-type strobes that must never enable the bus (refresh or deselect).
    task automatic rd_blocked(input logic [15:0] a, input bit slot, input bit rfsh, input string tag);
        @(negedge clk);
        bus.addr    = a;
        bus.nsltsl3 = !slot;
        bus.nrfshd  = !rfsh;
        bus.nrdd    = 1'b0;
        bus.nmreq   = 1'b0;
        bus.nmreqd  = 1'b0;
        #1 chk(tag, bus_z, 1'b1);
        @(negedge clk);
        chk(tag, bus_z, 1'b1);
        idle_bus();
    endtask

    task automatic model_reset();
`ifdef RAM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 65536; i++) begin
            mdl[i]   = 8'h00;
            known[i] = 1'b1;
        end
`endif
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 70000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.ready, 1'b1);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        int          op;

        for (int i = 0; i < 65536; i++) known[i] = 1'b0;
        tb_dat   = 8'h00;
        bus.addr = 16'h0000;
        idle_bus();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", bus.ready, 1'b0);
        chk("reset_bus_z", bus_z, 1'b1);
        model_reset();
        rst = 1'b0;
        #1 chk("ready_after_rst_low", bus.ready, 1'b0);
        wait_ready("ready_rise");

        wr(16'h1234, 8'h42, 1'b1, 1'b0);
        rd(16'h1234);
        wr(16'h1234, 8'h55, 1'b1, 1'b1);
        rd_blocked(16'h1234, 1'b1, 1'b1, "rfsh_rd_z");
        rd(16'h1234);
        rd_blocked(16'h1234, 1'b0, 1'b0, "desel_rd_z");
        wr(16'h1234, 8'h99, 1'b0, 1'b0);
        rd(16'h1234);
        wr(16'h0000, 8'hA5, 1'b1, 1'b0);
        wr(16'hFFFF, 8'h5A, 1'b1, 1'b0);
        rd(16'h0000);
        rd(16'hFFFF);
        rd(16'h1234);

        // Address change inside a read: new address shows up after one clock.
        @(negedge clk);
        bus.addr    = 16'h0000;
        bus.nsltsl3 = 1'b0;
        bus.nrdd    = 1'b0;
        bus.nmreq   = 1'b0;
        bus.nmreqd  = 1'b0;
        @(negedge clk);
        chk("addr_chg_first", data, 8'hA5);
        bus.addr = 16'hFFFF;
        @(negedge clk);
        chk("addr_chg_second", data, 8'h5A);
        idle_bus();

        // Write switches straight to read with no idle edge between them.
        @(negedge clk);
        bus.addr    = 16'h4321;
        tb_dat      = 8'hC3;
        tb_drv      = 1'b1;
        bus.nsltsl3 = 1'b0;
        bus.nrdd    = 1'b1;
        bus.nmreq   = 1'b0;
        bus.nmreqd  = 1'b0;
        @(negedge clk);
        tb_drv   = 1'b0;
        bus.nrdd = 1'b0;
        mdl[16'h4321]   = 8'hC3;
        known[16'h4321] = 1'b1;
        wr_addrs.push_back(16'h4321);
        @(negedge clk);
        chk("wr_to_rd", data, 8'hC3);
        idle_bus();

        for (int k = 0; k < 300; k++) begin
            op = int'($urandom_range(0, 9));
            a  = 16'($urandom);
            d  = 8'($urandom);
            if (op <= 3) begin
                wr(a, d, 1'b1, 1'b0);
            end else if (op <= 7) begin
                a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                rd(a);
            end else if (op == 8) begin
                wr(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)], d, 1'b1, 1'b1);
            end else begin
                wr(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)], d, 1'b0, 1'b0);
            end
        end

        wr(16'h1234, 8'h42, 1'b1, 1'b0);
        @(negedge clk);
        rst         = 1'b1;
        bus.addr    = 16'h1234;
        bus.nsltsl3 = 1'b0;
        bus.nrdd    = 1'b0;
        bus.nmreq   = 1'b0;
        bus.nmreqd  = 1'b0;
        #1 chk("rst_rd_z", bus_z, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_rd_z_held", bus_z, 1'b1);
        chk("rst_ready_low", bus.ready, 1'b0);
        idle_bus();
        model_reset();
        rst = 1'b0;
        #1 chk("ready_after_rst2", bus.ready, 1'b0);
        wait_ready("ready_rise2");
        rd(16'h1234);
        rd(16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
